// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud-rate helpers.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: pulses o_bit_end on the last clock of every CLKS_PER_BIT-cycle bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = calc_cnt_w(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input; even parity bit added when
// UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_tx
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned BIT_CNT_W    = $clog2(DATA_W);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_e            r_state, w_state_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [DATA_W-1:0]      r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic                   w_bit_end;
  logic                   w_clear;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_parity_nxt;
`endif

  // Counter is held at zero while idle, so acceptance starts a fresh bit time.
  assign w_clear = (r_state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  // Line value for the next cycle is decided here so o_tx stays a flop output.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_ready_nxt   = r_ready;
    w_busy_nxt    = r_busy;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_valid && r_ready) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = i_data;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = 1'b0;
          w_ready_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt  = ^i_data;
`endif
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = ST_PARITY;
            w_tx_nxt      = r_parity;
`else
            w_state_nxt   = ST_STOP;
            w_tx_nxt      = 1'b1;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; covers UART_TX_PARITY_EN when defined.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_busy;
  logic       o_tx;

  int total;
  int bad;

  uart_tx #(
    .CLK_FREQ_HZ(1600),
    .BAUD_RATE  (100)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_busy (o_busy),
    .o_tx   (o_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and steps through the acceptance edge.
  task automatic accept(input logic [7:0] b, input logic hold, input string nm);
    i_data  = b;
    i_valid = 1'b1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_before: got %b want 1", nm, o_ready);
    end
    tick();
    if (!hold) i_valid = 1'b0;
    total++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_accept: tx=%b busy=%b ready=%b want 0 1 0", nm, o_tx, o_busy, o_ready);
    end
  endtask

  // Called one cycle after acceptance; checks every line cycle, decodes at mid-bit.
  task automatic check_frame(input logic [7:0] b, input string nm, input int pulse_at,
                             input logic [7:0] pdat, output logic par);
    logic       exp_bits [0:10];
    logic [7:0] rx;
    logic       s_start;
    logic       s_stop;
    int         badc;
    int         n;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    exp_bits[9]  = (NB == 11) ? ^b : 1'b1;
    exp_bits[10] = 1'b1;
    rx = 8'h00; s_start = 1'bx; s_stop = 1'bx; par = 1'b0;
    n = 1;
    for (int bit_i = 0; bit_i < NB; bit_i++) begin
      badc = 0;
      for (int c = 0; c < CPB; c++) begin
        if (o_tx !== exp_bits[bit_i] || o_busy !== 1'b1 || o_ready !== 1'b0) badc++;
        if (c == CPB / 2) begin
          if (bit_i == 0) s_start = o_tx;
          else if (bit_i <= 8) rx[bit_i-1] = o_tx;
          else if (bit_i == NB - 1) s_stop = o_tx;
          else par = o_tx;
        end
        if (pulse_at != 0 && n == pulse_at) begin
          i_valid = 1'b1;
          i_data  = pdat;
        end
        if (pulse_at != 0 && n == pulse_at + 1) i_valid = 1'b0;
        tick();
        n++;
      end
      total++;
      if (badc != 0) begin
        bad++;
        $display("FAIL %s_bit%0d: %0d bad cycles, want tx=%b busy=1 ready=0",
                 nm, bit_i, badc, exp_bits[bit_i]);
      end
    end
    total++;
    if (rx !== b || s_start !== 1'b0 || s_stop !== 1'b1) begin
      bad++;
      $display("FAIL %s_decode: got %h start=%b stop=%b want %h 0 1", nm, rx, s_start, s_stop, b);
    end
    total++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end_idle: tx=%b ready=%b busy=%b want 1 1 0", nm, o_tx, o_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    int badc;
    rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00;
    #23;
    total++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b want 1 1 0", o_tx, o_ready, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    badc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) badc++;
    end
    total++;
    if (badc != 0) begin
      bad++;
      $display("FAIL reset_idle: %0d bad cycles, want tx=1 ready=1 busy=0", badc);
    end
  endtask

  task automatic test_single();
    logic p;
    accept(8'hA5, 1'b0, "a5");
    check_frame(8'hA5, "a5", 0, 8'h00, p);
  endtask

  task automatic test_back_to_back();
    logic p;
    accept(8'h00, 1'b1, "b2b0");
    i_data = 8'hFF;
    check_frame(8'h00, "b2b0", 0, 8'h00, p);
    tick();
    total++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: tx=%b busy=%b want 0 1 after one idle cycle", o_tx, o_busy);
    end
    check_frame(8'hFF, "b2b1", 0, 8'h00, p);
    i_valid = 1'b0;
  endtask

  task automatic test_valid_while_busy();
    logic p;
    int   badc;
    accept(8'h81, 1'b0, "busy");
    check_frame(8'h81, "busy", 50, 8'h3C, p);
    badc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_tx !== 1'b1 || o_busy !== 1'b0) badc++;
    end
    total++;
    if (badc != 0) begin
      bad++;
      $display("FAIL busy_no_extra: %0d cycles active, want line idle", badc);
    end
  endtask

  task automatic test_mid_reset();
    logic p;
    int   badc;
    accept(8'h55, 1'b0, "rst55");
    for (int i = 0; i < 40; i++) tick();
    total++;
    if (o_tx !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_bit: tx=%b want 0", o_tx);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async: tx=%b busy=%b ready=%b want 1 0 1", o_tx, o_busy, o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    badc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_tx !== 1'b1 || o_busy !== 1'b0) badc++;
    end
    total++;
    if (badc != 0) begin
      bad++;
      $display("FAIL rst_no_retain: %0d active cycles, want idle", badc);
    end
    accept(8'h12, 1'b0, "post12");
    check_frame(8'h12, "post12", 0, 8'h00, p);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic p;
    accept(8'h07, 1'b0, "par07");
    check_frame(8'h07, "par07", 0, 8'h00, p);
    total++;
    if (p !== 1'b1) begin
      bad++;
      $display("FAIL par07_bit: got %b want 1", p);
    end
    tick();
    accept(8'h03, 1'b0, "par03");
    check_frame(8'h03, "par03", 0, 8'h00, p);
    total++;
    if (p !== 1'b0) begin
      bad++;
      $display("FAIL par03_bit: got %b want 0", p);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_valid_while_busy();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    tick();
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
